// File: rtl/bus_stream_fifo.sv
// Single-clock valid/ready FIFO with registered flags and a level count.
// Every output is derived from registered state, so no ready/valid path is combinational.
module bus_stream_fifo #(
  parameter int BUS_WIDTH = 32,
  parameter int DEPTH     = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  input  logic [BUS_WIDTH-1:0]       in_data,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic [BUS_WIDTH-1:0]       out_data,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [BUS_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [LVL_W-1:0]     cnt;
  logic                 push;
  logic                 pop;

  assign in_ready  = (cnt != LVL_W'(DEPTH));
  assign out_valid = (cnt != '0);
  assign out_data  = mem[rd_ptr];
  assign level     = cnt;

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  // Storage is never reset; stale entries are unreachable once the pointers clear.
  always_ff @(posedge clk) begin
    if (push && !flush && !rst)
      mem[wr_ptr] <= in_data;
  end

  // DEPTH is a power of two, so pointer increments wrap naturally.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)
        rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + LVL_W'(1);
        2'b01:   cnt <= cnt - LVL_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_stream_fifo.sv
// Bench for bus_stream_fifo: directed scenarios on a 32x4 instance, then random
// traffic on 32x4 and 8x2 instances against queue reference models.
module tb_bus_stream_fifo;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        flush_a = 1'b0, iv_a = 1'b0, ordy_a = 1'b0;
  logic [31:0] din_a = '0;
  logic        irdy_a, ov_a;
  logic [31:0] dout_a;
  logic [2:0]  lvl_a;

  logic        flush_b = 1'b0, iv_b = 1'b0, ordy_b = 1'b0;
  logic [7:0]  din_b = '0;
  logic        irdy_b, ov_b;
  logic [7:0]  dout_b;
  logic [1:0]  lvl_b;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  bus_stream_fifo #(.BUS_WIDTH(32), .DEPTH(4)) dut_a (
    .clk(clk), .rst(rst), .flush(flush_a),
    .in_valid(iv_a), .in_data(din_a), .in_ready(irdy_a),
    .out_valid(ov_a), .out_data(dout_a), .out_ready(ordy_a),
    .level(lvl_a)
  );

  bus_stream_fifo #(.BUS_WIDTH(8), .DEPTH(2)) dut_b (
    .clk(clk), .rst(rst), .flush(flush_b),
    .in_valid(iv_b), .in_data(din_b), .in_ready(irdy_b),
    .out_valid(ov_b), .out_data(dout_b), .out_ready(ordy_b),
    .level(lvl_b)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive_a(input logic iv, input logic [31:0] d, input logic ordy, input logic fl);
    iv_a = iv; din_a = d; ordy_a = ordy; flush_a = fl;
  endtask

  task automatic check_state_a(input string tag, input int lvl, input logic [31:0] head);
    check({tag, ".level"}, 64'(lvl_a), 64'(lvl));
    check({tag, ".out_valid"}, 64'(ov_a), 64'(lvl != 0));
    check({tag, ".in_ready"}, 64'(irdy_a), 64'(lvl != 4));
    if (lvl != 0) check({tag, ".out_data"}, 64'(dout_a), 64'(head));
  endtask

  logic [31:0] qa[$];
  logic [7:0]  qb[$];
  logic [31:0] exp_seq [5];

  initial begin
    // Reset held two cycles with in_valid asserted: nothing may be stored.
    @(negedge clk);
    rst = 1'b1;
    drive_a(1'b1, 32'hDEAD, 1'b0, 1'b0);
    tick();
    tick();
    rst = 1'b0;
    drive_a(1'b0, 32'h0, 1'b0, 1'b0);
    check_state_a("reset", 0, 32'h0);
    tick();
    check_state_a("reset_idle", 0, 32'h0);

    // Fill to full with out_ready low; fifth word held off.
    for (int i = 0; i < 4; i++) begin
      drive_a(1'b1, 32'hA0 + 32'(i), 1'b0, 1'b0);
      tick();
    end
    check_state_a("fill", 4, 32'hA0);
    drive_a(1'b1, 32'hA4, 1'b0, 1'b0);
    tick();
    check_state_a("full_hold", 4, 32'hA0);

    // Drain: A4 is rejected while full, then accepted once a slot frees.
    for (int k = 0; k < 5; k++) exp_seq[k] = 32'hA0 + 32'(k);
    for (int k = 0; k < 5; k++) begin
      check("drain.out_valid", 64'(ov_a), 64'(1));
      check("drain.out_data", 64'(dout_a), 64'(exp_seq[k]));
      drive_a(k <= 1, 32'hA4, 1'b1, 1'b0);
      tick();
    end
    drive_a(1'b0, 32'h0, 1'b0, 1'b0);
    check_state_a("drained", 0, 32'h0);

    // Streaming: constant valid/ready, level stays at one.
    drive_a(1'b1, 32'd0, 1'b1, 1'b0);
    tick();
    for (int i = 1; i < 16; i++) begin
      check("stream.level", 64'(lvl_a), 64'(1));
      check("stream.out_data", 64'(dout_a), 64'(i - 1));
      drive_a(1'b1, 32'(i), 1'b1, 1'b0);
      tick();
    end
    check_state_a("stream_end", 1, 32'd15);
    drive_a(1'b0, 32'h0, 1'b1, 1'b0);
    tick();
    check_state_a("stream_empty", 0, 32'h0);

    // Full with simultaneous pop: pop only, push accepted the cycle after.
    for (int i = 0; i < 4; i++) begin
      drive_a(1'b1, 32'hB0 + 32'(i), 1'b0, 1'b0);
      tick();
    end
    drive_a(1'b1, 32'hB4, 1'b1, 1'b0);
    tick();
    check_state_a("full_pop", 3, 32'hB1);
    drive_a(1'b1, 32'hB4, 1'b0, 1'b0);
    tick();
    check_state_a("full_refill", 4, 32'hB1);
    drive_a(1'b0, 32'h0, 1'b1, 1'b0);
    tick();
    check_state_a("pre_flush", 3, 32'hB2);

    // Flush with push and pop asserted discards everything.
    drive_a(1'b1, 32'hEE, 1'b1, 1'b1);
    tick();
    check_state_a("flush", 0, 32'h0);
    drive_a(1'b1, 32'h55, 1'b0, 1'b0);
    tick();
    check_state_a("post_flush", 1, 32'h55);
    drive_a(1'b0, 32'h0, 1'b1, 1'b0);
    tick();
    check_state_a("post_flush_pop", 0, 32'h0);

    // Reset mid-fill, with a push and flush pending: old words never reappear.
    drive_a(1'b1, 32'hC0, 1'b0, 1'b0);
    tick();
    drive_a(1'b1, 32'hC1, 1'b0, 1'b0);
    tick();
    rst = 1'b1;
    drive_a(1'b1, 32'hC2, 1'b1, 1'b1);
    tick();
    rst = 1'b0;
    drive_a(1'b0, 32'h0, 1'b0, 1'b0);
    check_state_a("reset_mid", 0, 32'h0);
    drive_a(1'b1, 32'h77, 1'b0, 1'b0);
    tick();
    check_state_a("reset_mid_push", 1, 32'h77);
    drive_a(1'b0, 32'h0, 1'b1, 1'b0);
    tick();
    check_state_a("reset_mid_pop", 0, 32'h0);

    // Random traffic on both instances against queue models.
    qa.delete();
    qb.delete();
    for (int c = 0; c < 1000; c++) begin
      check("rnd_a.level", 64'(lvl_a), 64'(qa.size()));
      check("rnd_a.out_valid", 64'(ov_a), 64'(qa.size() != 0));
      check("rnd_a.in_ready", 64'(irdy_a), 64'(qa.size() < 4));
      if (qa.size() != 0) check("rnd_a.out_data", 64'(dout_a), 64'(qa[0]));
      check("rnd_b.level", 64'(lvl_b), 64'(qb.size()));
      check("rnd_b.out_valid", 64'(ov_b), 64'(qb.size() != 0));
      check("rnd_b.in_ready", 64'(irdy_b), 64'(qb.size() < 2));
      if (qb.size() != 0) check("rnd_b.out_data", 64'(dout_b), 64'(qb[0]));

      iv_a = 1'($urandom_range(0, 1));
      ordy_a = 1'($urandom_range(0, 1));
      din_a = $urandom;
      flush_a = ($urandom_range(0, 49) == 0);
      iv_b = 1'($urandom_range(0, 1));
      ordy_b = 1'($urandom_range(0, 1));
      din_b = 8'($urandom);
      flush_b = ($urandom_range(0, 49) == 0);

      if (flush_a) qa.delete();
      else begin
        bit pu, po;
        pu = iv_a && (qa.size() < 4);
        po = ordy_a && (qa.size() > 0);
        if (po) void'(qa.pop_front());
        if (pu) qa.push_back(din_a);
      end
      if (flush_b) qb.delete();
      else begin
        bit pu, po;
        pu = iv_b && (qb.size() < 2);
        po = ordy_b && (qb.size() > 0);
        if (po) void'(qb.pop_front());
        if (pu) qb.push_back(din_b);
      end
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
